// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package key_debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

  // Counter width for a given debounce length; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for one asynchronous level; both flops reset to RESET_VAL.
module key_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces one push-button and emits a one-cycle key_pulse per qualified press.
// Optional release strobe key_release_pulse under macro DEBOUNCE_RELEASE_PULSE_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_pulse
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic key_release_pulse
`endif
);

  localparam logic          REL     = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s2;
  logic          db;
  logic          db_d;
  logic [CW-1:0] cnt;

  key_sync #(
    .RESET_VAL (REL)
  ) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (key),
    .q   (s2)
  );

  // db_d lags db by one edge so the strobe lands on the edge after db changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      db        <= REL;
      db_d      <= REL;
      key_pulse <= 1'b0;
    end else begin
      db_d      <= db;
      key_pulse <= (db != REL) && (db_d == REL);
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_release_pulse <= 1'b0;
    end else begin
      key_release_pulse <= (db == REL) && (db_d != REL);
    end
  end
`else
  // Release events are silent in this build.
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, active-low key.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst;
  logic key;
  logic key_pulse;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic key_release_pulse;
`endif

  int errors     = 0;
  int checks     = 0;
  int edge_no    = 0;
  int pulse_cnt  = 0;
  int last_pulse = -1;
  int rel_cnt    = 0;
  int last_rel   = -1;
  int e0;

  key_debounce #(
    .DEBOUNCE_CYCLES (8),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_pulse (key_pulse)
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    ,
    .key_release_pulse (key_release_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n edges, sampling 1 ns after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (key_pulse === 1'b1) begin
        pulse_cnt++;
        last_pulse = edge_no;
      end
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      if (key_release_pulse === 1'b1) begin
        rel_cnt++;
        last_rel = edge_no;
      end
`endif
    end
  endtask

  task automatic clear_counts();
    pulse_cnt  = 0;
    last_pulse = -1;
    rel_cnt    = 0;
    last_rel   = -1;
  endtask

  initial begin
    rst = 1'b1;
    key = 1'b0;
    #1;
    check("reset_async", {31'b0, key_pulse}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_hold", {31'b0, key_pulse}, 32'd0);
    end

    // Idle after reset with the key released.
    rst = 1'b0;
    key = 1'b1;
    clear_counts();
    tick(50);
    check("idle_pulses", pulse_cnt, 0);

    // Clean press, held long.
    key = 1'b0;
    e0  = edge_no + 1;
    clear_counts();
    tick(100);
    check("press_count", pulse_cnt, 1);
    check("press_edge", last_pulse, e0 + 10);

    // Release produces no key_pulse.
    key = 1'b1;
    e0  = edge_no + 1;
    clear_counts();
    tick(20);
    check("release_no_pulse", pulse_cnt, 0);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    check("release_count", rel_cnt, 1);
    check("release_edge", last_rel, e0 + 10);
`endif

    // Bounce: 3-cycle segments alternating low/high, then stable low.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick(3);
    end
    check("bounce_no_pulse", pulse_cnt, 0);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    check("bounce_no_release", rel_cnt, 0);
`endif
    key = 1'b0;
    e0  = edge_no + 1;
    clear_counts();
    tick(30);
    check("bounce_count", pulse_cnt, 1);
    check("bounce_edge", last_pulse, e0 + 10);
    key = 1'b1;
    tick(30);

    // Seven-cycle glitch is rejected.
    clear_counts();
    key = 1'b0;
    tick(7);
    key = 1'b1;
    tick(30);
    check("glitch7_pulses", pulse_cnt, 0);

    // Eight-cycle press is accepted.
    clear_counts();
    key = 1'b0;
    e0  = edge_no + 1;
    tick(8);
    key = 1'b1;
    tick(40);
    check("glitch8_count", pulse_cnt, 1);
    check("glitch8_edge", last_pulse, e0 + 10);

    // Reset in the middle of counting a press; key stays pressed.
    clear_counts();
    key = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check("midrst_async", {31'b0, key_pulse}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("midrst_hold", {31'b0, key_pulse}, 32'd0);
    end
    check("midrst_no_pulse", pulse_cnt, 0);
    rst = 1'b0;
    e0  = edge_no + 1;
    clear_counts();
    tick(30);
    check("midrst_count", pulse_cnt, 1);
    check("midrst_edge", last_pulse, e0 + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
